// File: rtl/simplearm_mem_pkg.sv
// Shared types for the memory bus master: access size, response error codes
// and the master FSM state encoding.
package simplearm_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_SIZE     = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_e;

  typedef enum logic [2:0] {
    MST_IDLE    = 3'd0,
    MST_STROBE  = 3'd1,
    MST_WAIT    = 3'd2,
    MST_CAPTURE = 3'd3,
    MST_RESP    = 3'd4
  } mst_state_e;

endpackage

// File: rtl/mem_bus_master_if.sv
// Memory bus between the initiator (master) and an SRAM-style responder.
//   addr    : word-aligned byte address      (master -> slave)
//   wdata   : lane-replicated store data     (master -> slave)
//   wr_en   : single-cycle write strobe      (master -> slave)
//   rd_en   : single-cycle read strobe       (master -> slave)
//   byte_en : lane enables                   (master -> slave)
//   rdata   : read data, valid the cycle after ready (slave -> master)
//   ready   : completion pulse               (slave -> master)
interface mem_bus_master_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              wr_en;
  logic              rd_en;
  logic [3:0]        byte_en;
  logic              ready;

  modport master (
    output addr, wdata, wr_en, rd_en, byte_en,
    input  rdata, ready
  );

  modport slave (
    input  addr, wdata, wr_en, rd_en, byte_en,
    output rdata, ready
  );
endinterface

// File: rtl/mem_lane_align.sv
// Purely combinational lane steering for the memory bus master.
//   addr_lo   : byte offset within the word
//   size      : access size
//   is_signed : sign-extend the load result
//   st_data   : right-justified store data
//   ld_word   : raw bus read word
//   byte_en   : lane enables for the access
//   st_lanes  : store data replicated onto every lane it may occupy
//   ld_result : selected load bytes, shifted down and extended
//   misalign  : half/word access not naturally aligned
//   illegal   : reserved size encoding
module mem_lane_align
  import simplearm_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        is_signed,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  byte_en,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_result,
  output logic        misalign,
  output logic        illegal
);

  logic [31:0] shifted;

  assign shifted = ld_word >> {addr_lo, 3'b000};

  always_comb begin
    byte_en   = 4'b0000;
    st_lanes  = 32'h0;
    ld_result = 32'h0;
    misalign  = 1'b0;
    illegal   = 1'b0;
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        st_lanes  = {4{st_data[7:0]}};
        ld_result = is_signed ? {{24{shifted[7]}}, shifted[7:0]}
                              : {24'h0, shifted[7:0]};
      end
      SZ_HALF: begin
        misalign  = addr_lo[0];
        byte_en   = 4'b0011 << addr_lo;
        st_lanes  = {2{st_data[15:0]}};
        ld_result = is_signed ? {{16{shifted[15]}}, shifted[15:0]}
                              : {16'h0, shifted[15:0]};
      end
      SZ_WORD: begin
        misalign  = |addr_lo;
        byte_en   = 4'b1111;
        st_lanes  = st_data;
        ld_result = shifted;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_master.sv
// Single-outstanding load/store initiator. Takes one request over a
// valid/ready channel, issues a one-cycle bus strobe, waits for the
// responder's ready pulse (or times out) and returns a held response.
//   clk, rst_n        : clock, synchronous active-low reset
//   req_*             : request channel (address, direction, size, sign, data)
//   resp_*            : response channel (extended load data, error + code)
//   bus               : memory bus, master side
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | req_ready high, bus quiet; latch request, pre-check errors
// STROBE  | one-cycle rd_en/wr_en with aligned addr, lanes, byte_en
// WAIT    | strobes low, bus payload held; count until ready or timeout
// CAPTURE | rdata valid this cycle; extract and extend into response
// RESP    | resp_valid high, payload held until resp_ready
module mem_bus_master
  import simplearm_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [1:0]        resp_err_code,
  mem_bus_master_if.master  bus
);

  localparam logic [2:0] S_IDLE    = MST_IDLE;
  localparam logic [2:0] S_STROBE  = MST_STROBE;
  localparam logic [2:0] S_WAIT    = MST_WAIT;
  localparam logic [2:0] S_CAPTURE = MST_CAPTURE;
  localparam logic [2:0] S_RESP    = MST_RESP;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  size_e             size_q, size_d;
  logic              signed_q, signed_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  err_e              code_q, code_d;

  // In IDLE the aligner looks at the incoming request so errors are known
  // before anything is latched; afterwards it works on the latched copy.
  logic        in_idle;
  logic [1:0]  al_addr_lo;
  size_e       al_size;
  logic [3:0]  al_byte_en;
  logic [31:0] al_st_lanes;
  logic [31:0] al_ld_result;
  logic        al_misalign;
  logic        al_illegal;

  assign in_idle    = (state_q == S_IDLE);
  assign al_addr_lo = in_idle ? req_addr[1:0] : addr_q[1:0];
  assign al_size    = in_idle ? size_e'(req_size) : size_q;

  mem_lane_align u_align (
    .addr_lo   (al_addr_lo),
    .size      (al_size),
    .is_signed (signed_q),
    .st_data   (wdata_q),
    .ld_word   (bus.rdata),
    .byte_en   (al_byte_en),
    .st_lanes  (al_st_lanes),
    .ld_result (al_ld_result),
    .misalign  (al_misalign),
    .illegal   (al_illegal)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    code_d   = code_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          write_d  = req_write;
          size_d   = size_e'(req_size);
          signed_d = req_signed;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          if (al_illegal) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            code_d  = ERR_SIZE;
          end else if (al_misalign) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            code_d  = ERR_MISALIGN;
          end else begin
            state_d = S_STROBE;
          end
        end
      end
      S_STROBE: begin
        cnt_d   = 8'h0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // ready is checked first so a pulse on the last allowed cycle
        // still completes the access.
        if (bus.ready) begin
          if (write_q) begin
            state_d = S_RESP;
            rdata_d = 32'h0;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
          end else begin
            state_d = S_CAPTURE;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          rdata_d = 32'h0;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      S_CAPTURE: begin
        state_d = S_RESP;
        rdata_d = al_ld_result;
        err_d   = 1'b0;
        code_d  = ERR_NONE;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      wdata_q  <= 32'h0;
      cnt_q    <= 8'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  logic bus_active;
  assign bus_active = (state_q == S_STROBE) || (state_q == S_WAIT);

  assign bus.addr    = bus_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.wdata   = (bus_active && write_q) ? al_st_lanes : 32'h0;
  assign bus.byte_en = bus_active ? al_byte_en : 4'b0000;
  assign bus.wr_en   = (state_q == S_STROBE) && write_q;
  assign bus.rd_en   = (state_q == S_STROBE) && !write_q;

  assign req_ready     = in_idle;
  assign resp_valid    = (state_q == S_RESP);
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign resp_err_code = code_q;

endmodule
